uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive stage of the UART. Consumes the 16x-oversampling enable `en_rx` from the baud enable generator (one-clock pulse every 24 clocks, i.e. 16 ticks per 384-clock bit). Recovers 8N1 frames from the asynchronous `rxd` line and presents each byte as a parallel word with a one-clock valid strobe to the downstream host logic. Also flags framing errors and suppresses false starts.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first.
- OVERSAMPLE, 16: `en_rx` ticks per bit. Must be a power of two and at least 8.

Ports:
- clk  input  1  system clock. All state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- en_rx  input  1  oversample tick, one clk wide, stable at posedge clk.
- rxd  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last good byte. Holds until the next good frame.
- rx_valid  output  1  one-clk pulse; `rx_data` is new in the same cycle.
- rx_frame_err  output  1  one-clk pulse; stop bit was sampled low.
- rx_busy  output  1  high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All decisions below use the synchronized value `rxs`.
- **Sampling rule:** state, counters and sampling advance only on clocks where `en_rx` = 1. On all other clocks everything holds, except that `rx_valid` and `rx_frame_err` return to 0.
- **Counters:** `tick_cnt` is log2(OVERSAMPLE) bits; `bit_cnt` is log2(DATA_BITS) bits. Both wrap naturally and are never compared beyond their range.
- **IDLE:** on a tick with `rxs` = 0, set tick_cnt←0 and go to START.
- **START:** on each tick, tick_cnt increments.
  - When a tick finds tick_cnt = OVERSAMPLE/2−1 (mid start bit):
    - `rxs` = 0: tick_cnt←0, bit_cnt←0, go to DATA.
    - `rxs` = 1: false start, go to IDLE with no outputs.
- **DATA:** on each tick, tick_cnt increments.
  - When a tick finds tick_cnt = OVERSAMPLE−1:
    - Shift right: shreg←{rxs, shreg[DATA_BITS−1:1]}.
    - tick_cnt←0, bit_cnt increments.
    - If bit_cnt was DATA_BITS−1, go to STOP.
- **STOP:** when a tick finds tick_cnt = OVERSAMPLE−1:
  - `rxs` = 1: rx_data←shreg, rx_valid←1, go to IDLE.
  - `rxs` = 0: rx_frame_err←1, rx_data unchanged, go to BREAK.
- **BREAK:** stays in BREAK while ticks see `rxs` = 0. The first tick that sees `rxs` = 1 goes to IDLE. A line held low therefore never produces repeated frames.
- **Simultaneous events:** a new start edge during STOP is ignored; it is seen from IDLE on the next tick. `rx_valid` and `rx_frame_err` are never high together.

## Timing
- **Reset values:** rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_busy = 0, state = IDLE, shreg = 0, counters = 0, synchronizer = 1.
- **Reset mid-frame:** the frame is dropped with no strobe, and all outputs take their reset values immediately (asynchronous).
- **Strobe width:** rx_valid and rx_frame_err are exactly one clk wide. They are registered in the cycle of the deciding tick and visible the following cycle.
- **Start detection:** happens within 2 clocks of synchronizer delay plus ≤1 tick period (24 clocks) of the falling edge.
- **Frame latency:** from the detecting tick to the stop decision is OVERSAMPLE/2 + OVERSAMPLE·DATA_BITS + OVERSAMPLE ticks = 152 ticks = 3648 clocks at the default rate.
- **Back-to-back frames:** the block returns to IDLE about half a bit before the nominal end of the stop bit, so a following start bit at 3840 clocks is caught.
- **Frequency tolerance:** ±3% baud mismatch must still receive correctly.

## Test plan
- **Single good byte:** 0xA5 as 8N1 at 384 clk/bit, en_rx every 24 clk → exactly one rx_valid pulse, rx_data = 0xA5, rx_frame_err never high, rx_busy low again before 3840 clk after the start edge.
- **Glitch:** `rxd` low for 100 clk then high → no rx_valid, no rx_frame_err, rx_busy drops back to 0 by the mid-start check, rx_data unchanged.
- **Framing error and break:** send 0x55 good, then 0x3C with the stop bit low and the line held low for 2000 clk, then released → one rx_frame_err pulse, rx_data stays 0x55, no extra strobes during the low hold. A following 0x81 is received as 0x81.
- **Back-to-back extremes:** 0x00 then 0xFF with no idle gap → two rx_valid pulses, 3840 clk apart, with data 0x00 then 0xFF.
- **Reset mid-frame:** assert rst during data bit 3 of 0xC3 → outputs go to 0 immediately and no strobe appears; after release, 0x7E is received correctly.
- **Enable stalled:** en_rx held 0 while `rxd` toggles → no state change, rx_busy stays 0, no strobes.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1-style serial receiver driven by a 16x oversample tick.
// Synchronizes the asynchronous line, hunts for a start bit, samples each
// data bit at its centre, checks the stop bit, and reports either a good
// byte (rx_valid) or a framing error (rx_frame_err). A line held low after
// a framing error parks the receiver in BREAK until the line returns high.
module uart_rx_core #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_rx,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Tick count at the centre of the start bit, and at the end of a full bit.
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state;
   logic [1:0]             sync;
   logic                   rxs;
   logic [TW-1:0]          tick_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shreg;

   // Two-flop synchronizer on the asynchronous line; resets to the idle level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], rxd};
      end
   end

   assign rxs     = sync[1];
   assign rx_busy = (state != S_IDLE);

   // Receive FSM: advances only on oversample ticks; strobes clear every clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         // NOTE: the strobes default low with non-blocking assignments; a later
         // assignment in this same block overrides it, so each strobe is one
         // clock wide without any separate clear logic.
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;

         if (en_rx) begin
            case (state)
               S_IDLE: begin
                  if (!rxs) begin
                     tick_cnt <= '0;
                     state    <= S_START;
                  end
               end

               S_START: begin
                  if (tick_cnt == TICK_MID) begin
                     if (!rxs) begin
                        // Start bit still low at its centre: a genuine frame.
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                     end else begin
                        // Line went back high: noise, not a start bit.
                        state <= S_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               S_DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     // LSB arrives first, so shift in from the top.
                     shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                     tick_cnt <= '0;
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_LAST) begin
                        state <= S_STOP;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               S_STOP: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (rxs) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                        state    <= S_IDLE;
                     end else begin
                        rx_frame_err <= 1'b1;
                        state        <= S_BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               S_BREAK: begin
                  // Wait for the line to be released so a held-low line
                  // cannot be mistaken for a stream of start bits.
                  if (rxs) begin
                     state <= S_IDLE;
                  end
               end

               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized serial frames against a queue of
// expected receive events. Each sent frame pushes the event it must produce
// (byte or framing error, plus the time of its start edge); a compare process
// matches every strobe against that queue and checks rx_data every cycle.
`timescale 1ns/1ps
module tb_uart_rx_core;

   localparam int BITP    = 384;   // clocks per bit at the nominal rate
   localparam int EN_PER  = 24;    // clocks per oversample tick
   localparam int LAT_MIN = 3650;  // start edge to strobe, lower bound (clocks)
   localparam int LAT_MAX = 3676;  // start edge to strobe, upper bound (clocks)

   logic       clk = 1'b0;
   logic       rst;
   logic       en_rx;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   uart_rx_core #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en_rx        (en_rx),
      .rxd          (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used to timestamp edges and strobes.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         t0;
   } exp_t;

   exp_t       exp_q[$];
   int         valid_t[$];
   logic [7:0] exp_data;
   int         n_valid = 0;
   int         n_err   = 0;
   bit         en_stall = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Advance n clocks and land 1 ns after the active edge.
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one frame; the line is left at the stop-bit level on return.
   task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int bitp);
      exp_t e;
      e.err  = !stop_bit;
      e.data = d;
      e.t0   = cyc;
      exp_q.push_back(e);
      rxd = 1'b0;
      hold(bitp);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         hold(bitp);
      end
      rxd = stop_bit;
      hold(bitp);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(exp_q.size() == 0, name, exp_q.size(), 0);
   endtask

   // Oversample tick: one clock high every EN_PER clocks unless stalled.
   initial begin
      int en_cnt;
      en_cnt = 0;
      en_rx  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         en_cnt = (en_cnt == EN_PER - 1) ? 0 : en_cnt + 1;
         en_rx  = !en_stall && (en_cnt == 0);
      end
   end

   // Compare process: every strobe must match the oldest expected event.
   initial begin
      exp_t e;
      int   lat;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check(!(rx_valid && rx_frame_err), "strobe_exclusive",
                  {rx_valid, rx_frame_err}, 0);
            if (rx_valid || rx_frame_err) begin
               check(exp_q.size() != 0, "strobe_expected", exp_q.size(), 1);
               if (exp_q.size() != 0) begin
                  e   = exp_q.pop_front();
                  lat = cyc - e.t0;
                  check(rx_frame_err == e.err, "strobe_kind", rx_frame_err, e.err);
                  check(lat >= LAT_MIN && lat <= LAT_MAX, "strobe_latency", lat, LAT_MIN);
                  // Good frame returns to IDLE; bad frame parks in BREAK.
                  check(rx_busy == e.err, "busy_after_decision", rx_busy, e.err);
                  if (!e.err) exp_data = e.data;
               end
               if (rx_valid) begin
                  n_valid++;
                  valid_t.push_back(cyc);
               end
               if (rx_frame_err) n_err++;
            end
            check(rx_data == exp_data, "rx_data_hold", rx_data, exp_data);
         end
      end
   end

   // Watchdog: the run must always terminate.
   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Main stimulus sequence.
   initial begin
      logic [7:0] c3;
      int         v0;
      int         e0;
      c3       = 8'hC3;
      rst      = 1'b1;
      rxd      = 1'b1;
      exp_data = 8'h00;
      hold(5);

      // Reset state.
      check(rx_data == 8'h00, "reset_rx_data", rx_data, 0);
      check(rx_valid == 1'b0, "reset_rx_valid", rx_valid, 0);
      check(rx_frame_err == 1'b0, "reset_rx_frame_err", rx_frame_err, 0);
      check(rx_busy == 1'b0, "reset_rx_busy", rx_busy, 0);
      rst = 1'b0;
      hold(50);

      // Single good byte.
      v0 = n_valid;
      e0 = n_err;
      send_frame(8'hA5, 1'b1, BITP);
      check(rx_busy == 1'b0, "a5_busy_by_3840", rx_busy, 0);
      wait_drain("a5_drain");
      check(rx_data == 8'hA5, "a5_data", rx_data, 8'hA5);
      check(n_valid - v0 == 1, "a5_one_valid", n_valid - v0, 1);
      check(n_err == e0, "a5_no_err", n_err - e0, 0);
      hold(100);

      // Glitch: 100 clocks low, then high.
      v0 = n_valid;
      rxd = 1'b0;
      hold(60);
      check(rx_busy == 1'b1, "glitch_busy_seen", rx_busy, 1);
      hold(40);
      rxd = 1'b1;
      hold(160);
      check(rx_busy == 1'b0, "glitch_busy_dropped", rx_busy, 0);
      check(n_valid == v0 && n_err == e0, "glitch_no_strobe", n_valid - v0, 0);
      check(rx_data == 8'hA5, "glitch_data_kept", rx_data, 8'hA5);
      hold(200);

      // Framing error followed by a long break, then a good byte.
      send_frame(8'h55, 1'b1, BITP);
      hold(200);
      e0 = n_err;
      send_frame(8'h3C, 1'b0, BITP);
      hold(2000);
      check(rx_busy == 1'b1, "break_busy", rx_busy, 1);
      check(n_err - e0 == 1, "break_one_err", n_err - e0, 1);
      check(rx_data == 8'h55, "break_data_kept", rx_data, 8'h55);
      rxd = 1'b1;
      hold(100);
      check(rx_busy == 1'b0, "break_released", rx_busy, 0);
      send_frame(8'h81, 1'b1, BITP);
      wait_drain("break_drain");
      check(rx_data == 8'h81, "after_break_data", rx_data, 8'h81);
      hold(100);

      // Back-to-back extremes with no idle gap.
      send_frame(8'h00, 1'b1, BITP);
      send_frame(8'hFF, 1'b1, BITP);
      wait_drain("b2b_drain");
      check(rx_data == 8'hFF, "b2b_data", rx_data, 8'hFF);
      if (valid_t.size() >= 2)
         check(valid_t[valid_t.size()-1] - valid_t[valid_t.size()-2] == 10 * BITP,
               "b2b_spacing", valid_t[valid_t.size()-1] - valid_t[valid_t.size()-2], 10 * BITP);
      else
         check(1'b0, "b2b_pulses", valid_t.size(), 2);
      hold(100);

      // Reset in the middle of data bit 3 of 0xC3.
      v0 = n_valid;
      rxd = 1'b0;
      hold(BITP);
      for (int i = 0; i < 3; i++) begin
         rxd = c3[i];
         hold(BITP);
      end
      rxd = c3[3];
      hold(BITP / 2);
      check(rx_busy == 1'b1, "prereset_busy", rx_busy, 1);
      #3;
      rst      = 1'b1;
      exp_data = 8'h00;
      #1;
      check(rx_data == 8'h00, "midrst_rx_data", rx_data, 0);
      check(rx_valid == 1'b0, "midrst_rx_valid", rx_valid, 0);
      check(rx_frame_err == 1'b0, "midrst_rx_frame_err", rx_frame_err, 0);
      check(rx_busy == 1'b0, "midrst_rx_busy", rx_busy, 0);
      rxd = 1'b1;
      hold(5);
      rst = 1'b0;
      hold(400);
      check(n_valid == v0, "midrst_no_strobe", n_valid - v0, 0);
      send_frame(8'h7E, 1'b1, BITP);
      wait_drain("midrst_drain");
      check(rx_data == 8'h7E, "after_rst_data", rx_data, 8'h7E);
      hold(100);

      // Enable stalled while the line toggles.
      v0 = n_valid;
      e0 = n_err;
      en_stall = 1'b1;
      hold(2);
      for (int i = 0; i < 30; i++) begin
         rxd = 1'($urandom_range(0, 1));
         for (int j = 0; j < 50; j++) begin
            hold(1);
            check(rx_busy == 1'b0, "stall_busy", rx_busy, 0);
         end
      end
      rxd = 1'b1;
      hold(5);
      en_stall = 1'b0;
      hold(100);
      check(n_valid == v0 && n_err == e0, "stall_no_strobe", n_valid - v0, 0);
      check(rx_data == 8'h7E, "stall_data_kept", rx_data, 8'h7E);

      // Randomized frames at up to +/-3% baud mismatch, some with bad stops.
      for (int f = 0; f < 6; f++) begin
         logic [7:0] d;
         bit         stop_bit;
         int         bitp;
         d        = 8'($urandom);
         stop_bit = ($urandom_range(0, 3) != 0);
         bitp     = $urandom_range(373, 395);
         send_frame(d, stop_bit, bitp);
         if (!stop_bit) begin
            hold($urandom_range(0, 800));
            rxd = 1'b1;
            hold(50);
         end
         hold($urandom_range(0, 300));
      end
      wait_drain("random_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
